// File: rtl/ulpi_reg_sequencer_if.sv
// rtl/ulpi_reg_sequencer_if.sv - ULPI register-port link signals plus host request/response bundle
interface ulpi_reg_sequencer_if;
   logic [5:0] reg_addr;
   logic [7:0] reg_data_write;
   logic       reg_enable;
   logic       reg_read_nwrite;
   logic [7:0] reg_data_read;
   logic       reg_done;
   logic       req_valid;
   logic       req_ready;
   logic [5:0] req_addr;
   logic       req_read_nwrite;
   logic [7:0] req_wdata;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_timeout;

   modport master (
      output reg_addr, reg_data_write, reg_enable, reg_read_nwrite,
      output req_ready, resp_valid, resp_data, resp_timeout,
      input  reg_data_read, reg_done,
      input  req_valid, req_addr, req_read_nwrite, req_wdata
   );

   modport slave (
      input  reg_addr, reg_data_write, reg_enable, reg_read_nwrite,
      input  req_ready, resp_valid, resp_data, resp_timeout,
      output reg_data_read, reg_done,
      output req_valid, req_addr, req_read_nwrite, req_wdata
   );
endinterface

// File: rtl/ulpi_reg_sequencer.sv
// rtl/ulpi_reg_sequencer.sv - ULPI PHY boot programming and host register access sequencer
// Optional read-back verify of each boot write: define ULPI_REG_VERIFY_EN.
module ulpi_reg_sequencer #(
   parameter int INIT_DELAY     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   ulpi_reg_sequencer_if.master bus,
   output logic                 init_done,
   output logic                 init_error
);

   typedef enum logic [2:0] {
      DELAY,
      INIT_ISSUE,
      INIT_WAIT,
`ifdef ULPI_REG_VERIFY_EN
      VERIFY_ISSUE,
      VERIFY_WAIT,
`endif
      READY,
      HOST_WAIT
   } state_t;

   state_t      state, state_n;
   logic [15:0] dly_cnt, dly_cnt_n;
   logic [9:0]  tcnt, tcnt_n;
   logic [1:0]  idx, idx_n;
   logic [5:0]  addr_n;
   logic [7:0]  wdata_n;
   logic        enable_n, rnw_n, ready_n;
   logic        resp_valid_n, resp_timeout_n;
   logic [7:0]  resp_data_n;
   logic        init_done_n, init_error_n;
   logic        advance, timeout_hit;

   // Boot table for passive high-speed sniffing
   function automatic logic [5:0] boot_addr(input logic [1:0] i);
      case (i)
         2'd0:    return 6'h0A;
         2'd1:    return 6'h07;
         default: return 6'h04;
      endcase
   endfunction

   function automatic logic [7:0] boot_data(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h00;
         2'd1:    return 8'h00;
         default: return 8'h48;
      endcase
   endfunction

   // tcnt holds the number of completed enabled cycles, so this is the last allowed one
   assign timeout_hit = (tcnt == 10'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= DELAY;
         dly_cnt             <= 16'(INIT_DELAY);
         tcnt                <= '0;
         idx                 <= '0;
         bus.reg_addr        <= '0;
         bus.reg_data_write  <= 8'h00;
         bus.reg_enable      <= 1'b0;
         bus.reg_read_nwrite <= 1'b0;
         bus.req_ready       <= 1'b0;
         bus.resp_valid      <= 1'b0;
         bus.resp_data       <= 8'h00;
         bus.resp_timeout    <= 1'b0;
         init_done           <= 1'b0;
         init_error          <= 1'b0;
      end else begin
         state               <= state_n;
         dly_cnt             <= dly_cnt_n;
         tcnt                <= tcnt_n;
         idx                 <= idx_n;
         bus.reg_addr        <= addr_n;
         bus.reg_data_write  <= wdata_n;
         bus.reg_enable      <= enable_n;
         bus.reg_read_nwrite <= rnw_n;
         bus.req_ready       <= ready_n;
         bus.resp_valid      <= resp_valid_n;
         bus.resp_data       <= resp_data_n;
         bus.resp_timeout    <= resp_timeout_n;
         init_done           <= init_done_n;
         init_error          <= init_error_n;
      end
   end

   always_comb begin
      state_n        = state;
      dly_cnt_n      = dly_cnt;
      tcnt_n         = tcnt;
      idx_n          = idx;
      addr_n         = bus.reg_addr;
      wdata_n        = bus.reg_data_write;
      enable_n       = bus.reg_enable;
      rnw_n          = bus.reg_read_nwrite;
      ready_n        = 1'b0;
      resp_valid_n   = 1'b0;
      resp_data_n    = 8'h00;
      resp_timeout_n = 1'b0;
      init_done_n    = init_done;
      init_error_n   = init_error;
      advance        = 1'b0;

      case (state)
         DELAY: begin
            if (dly_cnt <= 16'd1) begin
               dly_cnt_n = '0;
               idx_n     = '0;
               state_n   = INIT_ISSUE;
            end else begin
               dly_cnt_n = dly_cnt - 16'd1;
            end
         end
         INIT_ISSUE: begin
            addr_n   = boot_addr(idx);
            wdata_n  = boot_data(idx);
            rnw_n    = 1'b0;
            enable_n = 1'b1;
            tcnt_n   = '0;
            state_n  = INIT_WAIT;
         end
         INIT_WAIT: begin
            tcnt_n = tcnt + 10'd1;
            if (bus.reg_done) begin
               enable_n = 1'b0;
`ifdef ULPI_REG_VERIFY_EN
               state_n  = VERIFY_ISSUE;
`else
               advance  = 1'b1;
`endif
            end else if (timeout_hit) begin
               enable_n     = 1'b0;
               init_error_n = 1'b1;
               advance      = 1'b1;
            end
         end
`ifdef ULPI_REG_VERIFY_EN
         VERIFY_ISSUE: begin
            rnw_n    = 1'b1;
            enable_n = 1'b1;
            tcnt_n   = '0;
            state_n  = VERIFY_WAIT;
         end
         VERIFY_WAIT: begin
            tcnt_n = tcnt + 10'd1;
            if (bus.reg_done) begin
               enable_n = 1'b0;
               advance  = 1'b1;
               if (bus.reg_data_read != boot_data(idx))
                  init_error_n = 1'b1;
            end else if (timeout_hit) begin
               enable_n     = 1'b0;
               init_error_n = 1'b1;
               advance      = 1'b1;
            end
         end
`endif
         READY: begin
            ready_n = 1'b1;
            if (bus.req_valid && bus.req_ready) begin
               addr_n   = bus.req_addr;
               wdata_n  = bus.req_wdata;
               rnw_n    = bus.req_read_nwrite;
               enable_n = 1'b1;
               tcnt_n   = '0;
               ready_n  = 1'b0;
               state_n  = HOST_WAIT;
            end
         end
         HOST_WAIT: begin
            tcnt_n = tcnt + 10'd1;
            if (bus.reg_done) begin
               enable_n     = 1'b0;
               resp_valid_n = 1'b1;
               resp_data_n  = bus.reg_read_nwrite ? bus.reg_data_read : 8'h00;
               state_n      = READY;
            end else if (timeout_hit) begin
               enable_n       = 1'b0;
               resp_valid_n   = 1'b1;
               resp_timeout_n = 1'b1;
               state_n        = READY;
            end
         end
         default: state_n = DELAY;
      endcase

      // A timed-out boot entry still moves on so the PHY gets the rest of the table
      if (advance) begin
         if (idx == 2'd2) begin
            init_done_n = 1'b1;
            state_n     = READY;
         end else begin
            idx_n   = idx + 2'd1;
            state_n = INIT_ISSUE;
         end
      end
   end

endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// tb/tb_ulpi_reg_sequencer.sv - directed bench for ulpi_reg_sequencer with a register-file link model
`timescale 1ns/1ps
module tb_ulpi_reg_sequencer;
   localparam int TOUT = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic init_done, init_error;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ulpi_reg_sequencer_if bus ();

   ulpi_reg_sequencer #(.INIT_DELAY(16), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .init_done  (init_done),
      .init_error (init_error)
   );

   // Link model state (written only by the link process)
   logic [7:0] regs [64] = '{0: 8'h24, default: 8'h00};
   logic [5:0] log_addr [$];
   logic [7:0] log_data [$];
   logic       log_rnw  [$];
   int         log_len  [$];
   logic [5:0] cur_addr;
   logic [7:0] cur_data;
   logic       cur_rnw;
   int         en_cycles = 0;
   int         low_cycles = 0;
   int         gap_viol = 0;
   int         stab_viol = 0;
   int         resp_cnt = 0;

   // Stimulus controls (written only by the main sequence)
   bit mute_all = 1'b0;
   int mute_addr = -1;
   int corrupt_addr = -1;

   always @(negedge clk) begin
      if (bus.resp_valid)
         resp_cnt++;
      if (bus.reg_enable) begin
         if (en_cycles == 0) begin
            if (low_cycles < 1)
               gap_viol++;
            low_cycles = 0;
            cur_addr = bus.reg_addr;
            cur_data = bus.reg_data_write;
            cur_rnw  = bus.reg_read_nwrite;
            log_addr.push_back(cur_addr);
            log_data.push_back(cur_data);
            log_rnw.push_back(cur_rnw);
         end else if ({bus.reg_addr, bus.reg_data_write, bus.reg_read_nwrite} !== {cur_addr, cur_data, cur_rnw}) begin
            stab_viol++;
         end
         en_cycles++;
         if (en_cycles == 2 && !mute_all && int'(cur_addr) != mute_addr) begin
            bus.reg_done = 1'b1;
            if (cur_rnw) begin
               bus.reg_data_read = (int'(cur_addr) == corrupt_addr) ? 8'h40 : regs[cur_addr];
            end else begin
               bus.reg_data_read = 8'hA5;
               regs[cur_addr] = cur_data;
            end
         end else begin
            bus.reg_done = 1'b0;
            bus.reg_data_read = 8'hA5;
         end
      end else begin
         if (en_cycles != 0)
            log_len.push_back(en_cycles);
         en_cycles = 0;
         low_cycles++;
         bus.reg_done = 1'b0;
         bus.reg_data_read = 8'hA5;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [5:0] exp_boot_addr(input int k);
      case (k)
         0:       return 6'h0A;
         1:       return 6'h07;
         default: return 6'h04;
      endcase
   endfunction

   function automatic logic [7:0] exp_boot_data(input int k);
      return (k == 2) ? 8'h48 : 8'h00;
   endfunction

   task automatic wait_init(input string tag);
      int t;
      t = 0;
      while (!init_done && t < 400) begin
         tick();
         t++;
      end
      chk(tag, t < 400, 1'b1);
   endtask

   task automatic count_to_enable(input string tag);
      int t;
      t = 0;
      while (!bus.reg_enable && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(tag, t, 17);
   endtask

   task automatic check_boot(input int start, input int mute_entry);
      int p;
      p = start;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("boot%0d_addr", k), log_addr[p], exp_boot_addr(k));
         chk($sformatf("boot%0d_data", k), log_data[p], exp_boot_data(k));
         chk($sformatf("boot%0d_write", k), log_rnw[p], 1'b0);
         chk($sformatf("boot%0d_len", k), log_len[p], (k == mute_entry) ? TOUT : 2);
         p++;
`ifdef ULPI_REG_VERIFY_EN
         if (k != mute_entry) begin
            chk($sformatf("verify%0d_addr", k), log_addr[p], exp_boot_addr(k));
            chk($sformatf("verify%0d_read", k), log_rnw[p], 1'b1);
            p++;
         end
`endif
      end
      chk("boot_access_count", log_addr.size(), p);
   endtask

   task automatic host_access(input logic rnw, input logic [5:0] a, input logic [7:0] d,
                              input logic [7:0] exp_data, input logic exp_to, input int exp_len);
      int t;
      int n0;
      n0 = resp_cnt;
      bus.req_valid = 1'b1;
      bus.req_read_nwrite = rnw;
      bus.req_addr = a;
      bus.req_wdata = d;
      t = 0;
      while (!bus.req_ready && t < 100) begin
         tick();
         t++;
      end
      chk("host_ready_wait", t < 100, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("host_enable_latency", bus.reg_enable, 1'b1);
      chk("host_addr", bus.reg_addr, a);
      chk("host_dir", bus.reg_read_nwrite, rnw);
      if (!rnw)
         chk("host_wdata", bus.reg_data_write, d);
      t = 0;
      while (!bus.resp_valid && t < 100) begin
         tick();
         t++;
      end
      chk("host_resp_wait", t < 100, 1'b1);
      chk("host_resp_data", bus.resp_data, exp_data);
      chk("host_resp_timeout", bus.resp_timeout, exp_to);
      chk("host_enable_dropped", bus.reg_enable, 1'b0);
      chk("host_ready_m1", bus.req_ready, 1'b0);
      chk("host_enable_len", log_len[$], exp_len);
      tick();
      chk("host_resp_single", bus.resp_valid, 1'b0);
      chk("host_ready_m2", bus.req_ready, 1'b1);
      chk("host_resp_count", resp_cnt - n0, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int t;
      int hs;
      int early;
      int base;
      int resp_base;

      bus.req_valid = 1'b0;
      bus.req_addr = '0;
      bus.req_read_nwrite = 1'b0;
      bus.req_wdata = 8'h00;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_reg_enable", bus.reg_enable, 1'b0);
      chk("rst_reg_addr", bus.reg_addr, 6'h00);
      chk("rst_reg_data_write", bus.reg_data_write, 8'h00);
      chk("rst_reg_read_nwrite", bus.reg_read_nwrite, 1'b0);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_timeout", bus.resp_timeout, 1'b0);
      chk("rst_resp_data", bus.resp_data, 8'h00);
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_init_error", init_error, 1'b0);

      // Normal boot
      reset = 1'b0;
      count_to_enable("boot_first_enable_cycle");
      wait_init("boot_done_wait");
      check_boot(0, -1);
      chk("boot_init_done", init_done, 1'b1);
      chk("boot_init_error", init_error, 1'b0);

      // Host accesses
      host_access(1'b1, 6'h00, 8'h00, 8'h24, 1'b0, 2);
      host_access(1'b0, 6'h15, 8'h3C, 8'h00, 1'b0, 2);
      host_access(1'b1, 6'h15, 8'h00, 8'h3C, 1'b0, 2);
      host_access(1'b1, 6'h04, 8'h00, 8'h48, 1'b0, 2);
      mute_all = 1'b1;
      host_access(1'b1, 6'h10, 8'h00, 8'h00, 1'b1, TOUT);

      // Reset during HOST_WAIT, then reboot with boot entry 1 unanswered
      bus.req_valid = 1'b1;
      bus.req_read_nwrite = 1'b1;
      bus.req_addr = 6'h11;
      t = 0;
      while (!bus.req_ready && t < 100) begin
         tick();
         t++;
      end
      chk("rst_mid_ready_wait", t < 100, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      tick();
      tick();
      chk("rst_mid_access_live", bus.reg_enable, 1'b1);
      resp_base = resp_cnt;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_enable_drop", bus.reg_enable, 1'b0);
      chk("rst_mid_no_resp", bus.resp_valid, 1'b0);
      chk("rst_mid_init_done_clr", init_done, 1'b0);
      reset = 1'b0;
      mute_all = 1'b0;
      mute_addr = 7;
      base = log_addr.size();
      count_to_enable("reboot_first_enable_cycle");
      wait_init("reboot_done_wait");
      chk("reboot_no_stale_resp", resp_cnt - resp_base, 0);
      check_boot(base, 1);
      chk("reboot_init_done", init_done, 1'b1);
      chk("reboot_init_error", init_error, 1'b1);

      // Request held high from reset
      mute_addr = -1;
      tick();
      reset = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_read_nwrite = 1'b0;
      bus.req_addr = 6'h20;
      bus.req_wdata = 8'h11;
      base = log_addr.size();
      @(posedge clk);
      #1;
      reset = 1'b0;
      early = 0;
      t = 0;
      while (!init_done && t < 400) begin
         tick();
         t++;
         if (bus.req_ready && !init_done)
            early++;
      end
      chk("held_init_wait", t < 400, 1'b1);
      chk("held_no_ready_before_init", early, 0);
      check_boot(base, -1);
      base = log_addr.size();
      resp_base = resp_cnt;
      hs = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.req_ready)
            hs++;
         tick();
      end
      bus.req_valid = 1'b0;
      repeat (10) tick();
      chk("held_access_per_handshake", log_addr.size() - base, hs);
      chk("held_resp_per_handshake", resp_cnt - resp_base, hs);
      chk("held_handshakes_seen", hs >= 5, 1'b1);

      // Boot with verify readback of 0x04 corrupted
      corrupt_addr = 4;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_init("corrupt_init_wait");
`ifdef ULPI_REG_VERIFY_EN
      chk("verify_mismatch_error", init_error, 1'b1);
`else
      chk("no_verify_error", init_error, 1'b0);
`endif
      corrupt_addr = -1;

      chk("link_enable_gap_violations", gap_viol, 0);
      chk("link_stability_violations", stab_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ulpi_reg_sequencer.md
# ulpi_reg_sequencer

Register-access initiator for the ULPI link's register port: drives `reg_addr`/`reg_data_write`/`reg_enable`/`reg_read_nwrite` and consumes `reg_done`/`reg_data_read`. After reset it programs the PHY with a fixed boot table for passive high-speed sniffing. It then arbitrates single register reads and writes from a host-side request port. It sits between the gateway control logic and the link block, on the same clock.

## Interface
- `INIT_DELAY`, 16: cycles after reset release before the first boot access.
- `TIMEOUT_CYCLES`, 255: maximum cycles `reg_enable` is held without `reg_done` (range 1..1023).
- `clk`  in  1  system clock (ULPI 60 MHz domain).
- `reset`  in  1  synchronous, active-high reset.
- `reg_addr`  out  6  register address to link.
- `reg_data_write`  out  8  write data to link.
- `reg_enable`  out  1  access request to link.
- `reg_read_nwrite`  out  1  1 = read, 0 = write.
- `reg_data_read`  in  8  read data from link; valid when `reg_done`=1.
- `reg_done`  in  1  link access-complete strobe.
- `req_valid`  in  1  host request.
- `req_ready`  out  1  sequencer accepts host request this cycle.
- `req_addr`  in  6  host address.
- `req_read_nwrite`  in  1  host direction.
- `req_wdata`  in  8  host write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  8  read data (0x00 for writes/timeouts).
- `resp_timeout`  out  1  qualifies `resp_valid`: access timed out.
- `init_done`  out  1  boot table finished (sticky until reset).
- `init_error`  out  1  any boot access timed out or failed verify (sticky).

## Operation
- Boot table, issued in order, all writes:
  - entry 0: addr 0x0A (OTG Control) ← 0x00
  - entry 1: addr 0x07 (Interface Control) ← 0x00
  - entry 2: addr 0x04 (Function Control) ← 0x48
- States: `DELAY` → `INIT_ISSUE` → `INIT_WAIT` → (`VERIFY_ISSUE` → `VERIFY_WAIT`) → next entry or `READY`; `READY` → `HOST_WAIT` → `READY`.
- `DELAY`: counter loads `INIT_DELAY` on reset, decrements to 0, then moves to `INIT_ISSUE` with entry index 0.
- `INIT_WAIT`:
  - on `reg_done`, advance the entry; after entry 2, set `init_done` and go to `READY`.
  - on timeout, set `init_error` and advance anyway.
- `READY`: `req_ready`=1. If `req_valid`=1, latch addr/dir/data, drive the access, and go to `HOST_WAIT`. `req_ready` is 0 in every other state.
- `HOST_WAIT`:
  - on `reg_done`, pulse `resp_valid`. `resp_data` is `reg_data_read` for reads, 0x00 for writes.
  - on timeout, pulse `resp_valid` with `resp_timeout`=1 and `resp_data`=0x00.
- Host requests are never accepted before `init_done`.
- Outputs at reset:
  - `reg_enable`, `req_ready`, `resp_valid`, `resp_timeout`, `init_done`, `init_error` = 0
  - `reg_addr` = 0, `reg_data_write` = 0x00, `reg_read_nwrite` = 0, `resp_data` = 0x00

## Timing
- All outputs are registered.
- Link handshake:
  - `reg_enable` rises together with stable addr/data/dir.
  - These stay constant while `reg_enable`=1.
  - `reg_enable` falls on the cycle after `reg_done` is sampled high.
- `reg_data_read` is captured in the cycle `reg_done`=1.
- `reg_enable` is low for at least one cycle between consecutive accesses.
- `reg_done` seen while `reg_enable`=0 is ignored.
- Host latency: `req_valid`&`req_ready` at cycle N → `reg_enable` high at N+1. `reg_done` at cycle M → `resp_valid` at M+1 and `reg_enable` low at M+1; `req_ready` returns at M+2.
- Timeout counter:
  - clears when `reg_enable` rises and counts each cycle `reg_enable`=1.
  - when it reaches `TIMEOUT_CYCLES` without `reg_done`, `reg_enable` drops next cycle.
  - the access is terminated; `reg_done` and timeout in the same cycle count as done.
- First boot access: `reg_enable` rises `INIT_DELAY`+1 cycles after `reset` deasserts.
- `reset` mid-access drops `reg_enable` the next cycle and restarts from `DELAY`. Any pending host response is discarded.

## Configuration
- `ULPI_REG_VERIFY_EN` defined: after each successful boot write, issue a read of the same address (`VERIFY_ISSUE`/`VERIFY_WAIT`). If the read data differs from the written value, or the read times out, set `init_error`. Adds 3 read accesses to boot.
- Undefined: verify states are absent and boot is 3 writes only.

## Test plan
- Reset release, link answers `reg_done` 2 cycles after each `reg_enable` → writes (0x0A,0x00), (0x07,0x00), (0x04,0x48) in order, first `reg_enable` at cycle 17; `init_done`=1, `init_error`=0.
- After init, host read addr 0x00, link returns 0x24 → single `resp_valid` with `resp_data`=0x24, `resp_timeout`=0; `reg_read_nwrite`=1 throughout.
- `TIMEOUT_CYCLES`=8, link never asserts `reg_done` on boot entry 1 → `reg_enable` held exactly 8 cycles and dropped; entry 2 still issued; `init_error`=1, `init_done`=1.
- `req_valid` held high from reset → not accepted until `init_done`; exactly one access issued per `req_ready` handshake; `reg_enable` low ≥1 cycle between accesses.
- Assert `reset` during `HOST_WAIT` → `reg_enable`=0 next cycle, no `resp_valid`, boot sequence restarts after `INIT_DELAY`.
- With `ULPI_REG_VERIFY_EN`, link returns 0x40 on verify of addr 0x04 → `init_error`=1; with matching 0x48 → `init_error`=0.
